// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access sequencer and its arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, grant id constants, and the poison word
// returned on a read that timed out.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Grant id stored with each transaction; also the arbiter's pointer encoding.
  localparam logic GNT_DATA  = 1'b0;
  localparam logic GNT_FETCH = 1'b1;

  // Read result delivered when the bus never answers.
  localparam logic [31:0] POISON = 32'hDEADBEEF;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin arbiter between the data port and the fetch port.
// Latency: grant is combinational from the requests; the pointer updates on the upd edge.
// Backpressure: none; the caller pulses upd only when it accepts the grant.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   req_d, req_i   data-port / fetch-port request
//   upd            pulse on the edge the grant is taken; records the winner
//   gnt[1:0]       one-hot grant, bit 0 = data port, bit 1 = fetch port
module mem_rr_arbiter
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_d,
  input  logic       req_i,
  input  logic       upd,
  output logic [1:0] gnt
);

  // Last port granted. Resets to fetch so the data port wins the first tie.
  logic last_q;
  logic last_d;

  always_comb begin
    gnt = 2'b00;
    if (req_d && req_i) begin
      // Tie: whoever was not served last goes next.
      gnt = (last_q == GNT_FETCH) ? 2'b01 : 2'b10;
    end else if (req_d) begin
      gnt = 2'b01;
    end else if (req_i) begin
      gnt = 2'b10;
    end
  end

  always_comb begin
    last_d = last_q;
    if (upd && (gnt != 2'b00)) begin
      last_d = gnt[1] ? GNT_FETCH : GNT_DATA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= GNT_FETCH;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer sharing one external memory bus between the data and fetch ports.
// Latency: 1 (grant) + N (BUSY, N>=1, through the response edge) + 1 (DONE) cycles.
// Backpressure: a port is stalled until its one-cycle done pulse; one transaction in flight.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   d_rd/d_wr/d_addr/d_wdata          data-port request (rd+wr together = write)
//   d_rdata/d_done                    data-port result and completion pulse
//   i_rd/i_addr                       fetch-port read request
//   i_rdata/i_done                    fetch-port result and completion pulse
//   busy                              high while in BUSY or DONE
//   memory_*                          external bus; all outputs registered
//   err                               sticky timeout flag
//
// Build option MEM_TIMEOUT_EN: aborts a transaction after TIMEOUT BUSY cycles
// without a response, completes it with POISON read data and sets err.
// Without it BUSY waits forever and err is constant 0.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d_rd,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  input  logic          i_rd,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_done,
  output logic          busy,
  output logic [31:0]   memory_addr,
  output logic          memory_rden,
  output logic          memory_wren,
  output logic [31:0]   memory_write_val,
  input  logic [31:0]   memory_read_val,
  input  logic          memory_response,
  output logic          err
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic          wr_q, wr_d;
  logic          gnt_id_q, gnt_id_d;
  logic          rden_q, rden_d;
  logic          wren_q, wren_d;
  logic          d_done_q, d_done_d;
  logic          i_done_q, i_done_d;
  logic          busy_q, busy_d;

  // Transaction completion in BUSY, and the value to hand back on a read.
  logic          fin;
  logic [DW-1:0] fin_rdata;

  logic [1:0]    arb_gnt;
  logic          arb_upd;

`ifdef MEM_TIMEOUT_EN
  // Counts BUSY cycles 0..TIMEOUT-1; the edge at TIMEOUT-1 is the last one allowed.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          err_q, err_d;
`endif

  // Only offer requests to the arbiter in IDLE so the pointer cannot move
  // while a transaction is outstanding.
  mem_rr_arbiter u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_d ((d_rd | d_wr) && (state_q == IDLE)),
    .req_i (i_rd && (state_q == IDLE)),
    .upd   (arb_upd),
    .gnt   (arb_gnt)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    d_rdata_d = d_rdata_q;
    i_rdata_d = i_rdata_q;
    wr_d      = wr_q;
    gnt_id_d  = gnt_id_q;
    rden_d    = rden_q;
    wren_d    = wren_q;
    d_done_d  = 1'b0;
    i_done_d  = 1'b0;
    arb_upd   = 1'b0;
    fin       = 1'b0;
    fin_rdata = DW'(memory_read_val);
`ifdef MEM_TIMEOUT_EN
    tmr_d     = tmr_q;
    err_d     = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          arb_upd = 1'b1;
          if (arb_gnt[1]) begin
            gnt_id_d = GNT_FETCH;
            addr_d   = i_addr;
            wr_d     = 1'b0;
          end else begin
            gnt_id_d = GNT_DATA;
            addr_d   = d_addr;
            wdata_d  = d_wdata;
            // A simultaneous read and write is issued as a write.
            wr_d     = d_wr;
          end
          rden_d  = ~wr_d;
          wren_d  = wr_d;
          state_d = BUSY;
`ifdef MEM_TIMEOUT_EN
          tmr_d   = '0;
`endif
        end
      end

      BUSY: begin
        if (memory_response) begin
          fin = 1'b1;
`ifdef MEM_TIMEOUT_EN
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          fin       = 1'b1;
          fin_rdata = DW'(POISON);
          err_d     = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
`endif
        end

        if (fin) begin
          if (!wr_q) begin
            if (gnt_id_q == GNT_FETCH) begin
              i_rdata_d = fin_rdata;
            end else begin
              d_rdata_d = fin_rdata;
            end
          end
          rden_d   = 1'b0;
          wren_d   = 1'b0;
          d_done_d = (gnt_id_q == GNT_DATA);
          i_done_d = (gnt_id_q == GNT_FETCH);
          state_d  = DONE;
        end
      end

      DONE: begin
        // Requests are not looked at here; the requester may be updating them.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        rden_d  = 1'b0;
        wren_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      d_rdata_q <= '0;
      i_rdata_q <= '0;
      wr_q      <= 1'b0;
      gnt_id_q  <= GNT_DATA;
      rden_q    <= 1'b0;
      wren_q    <= 1'b0;
      d_done_q  <= 1'b0;
      i_done_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmr_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      d_rdata_q <= d_rdata_d;
      i_rdata_q <= i_rdata_d;
      wr_q      <= wr_d;
      gnt_id_q  <= gnt_id_d;
      rden_q    <= rden_d;
      wren_q    <= wren_d;
      d_done_q  <= d_done_d;
      i_done_q  <= i_done_d;
      busy_q    <= busy_d;
`ifdef MEM_TIMEOUT_EN
      tmr_q     <= tmr_d;
      err_q     <= err_d;
`endif
    end
  end

  // Bus side is fixed at 32 bits; address/data are resized to fit.
  assign memory_addr      = 32'(addr_q);
  assign memory_write_val = 32'(wdata_q);
  assign memory_rden      = rden_q;
  assign memory_wren      = wren_q;
  assign d_rdata          = d_rdata_q;
  assign i_rdata          = i_rdata_q;
  assign d_done           = d_done_q;
  assign i_done           = i_done_q;
  assign busy             = busy_q;

`ifdef MEM_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        d_rd = 1'b0, d_wr = 1'b0, i_rd = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0, i_addr = '0;
  logic [31:0] d_rdata, i_rdata;
  logic        d_done, i_done, busy;
  logic [31:0] memory_addr, memory_write_val;
  logic        memory_rden, memory_wren;
  logic [31:0] memory_read_val = '0;
  logic        memory_response = 1'b0;
  logic        err;

  always #5 clk = ~clk;

  mem_access_ctrl #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .d_rd             (d_rd),
    .d_wr             (d_wr),
    .d_addr           (d_addr),
    .d_wdata          (d_wdata),
    .d_rdata          (d_rdata),
    .d_done           (d_done),
    .i_rd             (i_rd),
    .i_addr           (i_addr),
    .i_rdata          (i_rdata),
    .i_done           (i_done),
    .busy             (busy),
    .memory_addr      (memory_addr),
    .memory_rden      (memory_rden),
    .memory_wren      (memory_wren),
    .memory_write_val (memory_write_val),
    .memory_read_val  (memory_read_val),
    .memory_response  (memory_response),
    .err              (err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: memory contents, per-port expected rdata, RR pointer, err.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_d_rdata = '0;
  logic [31:0] exp_i_rdata = '0;
  bit          last_fetch  = 1'b1;
  bit          exp_err     = 1'b0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Waits for the strobe, checks the bus, answers after dly strobe cycles and
  // checks completion. cyc = negedges from call to the done sample.
  task automatic serve(input bit port, input bit is_wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int dly, input bit scramble,
                       output int cyc);
    int k = 0;
    while (!(memory_rden || memory_wren) && k < 6) begin
      step();
      k++;
    end
    cyc = k;
    check1("rden", memory_rden, !is_wr);
    check1("wren", memory_wren, is_wr);
    check32("bus_addr", memory_addr, addr);
    if (is_wr) check32("bus_wval", memory_write_val, wdata);
    check1("busy_in_busy", busy, 1'b1);
    check1("no_done_busy", d_done || i_done, 1'b0);
    if (scramble) begin
      d_addr  = $urandom;
      i_addr  = $urandom;
      d_wdata = $urandom;
    end
    for (int j = 1; j < dly; j++) begin
      step();
      cyc++;
      check32("addr_stable", memory_addr, addr);
      check1("strobe_held", memory_rden || memory_wren, 1'b1);
    end
    memory_read_val = is_wr ? $urandom : mem_rd(addr);
    memory_response = 1'b1;
    step();
    cyc++;
    memory_response = 1'b0;
    memory_read_val = $urandom;
    if (is_wr) mem[addr] = wdata;
    else if (port) exp_i_rdata = mem_rd(addr);
    else exp_d_rdata = mem_rd(addr);
    last_fetch = port;
    check1("d_done", d_done, !port);
    check1("i_done", i_done, port);
    check32("d_rdata", d_rdata, exp_d_rdata);
    check32("i_rdata", i_rdata, exp_i_rdata);
    check1("strobe_drop", memory_rden || memory_wren, 1'b0);
    check1("busy_in_done", busy, 1'b1);
    check1("err", err, exp_err);
  endtask

  // Single-port transaction from IDLE, then drop the request during DONE.
  task automatic do_txn(input bit port, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int dly);
    int  cyc;
    bit  is_wr;
    is_wr = !port && wr;
    if (port) begin
      i_rd = 1'b1; i_addr = addr;
    end else begin
      d_rd = rd; d_wr = wr; d_addr = addr; d_wdata = wdata;
    end
    serve(port, is_wr, addr, wdata, dly, 1'b1, cyc);
    check32("latency", 32'(cyc + 1), 32'(dly + 2));
    d_rd = 1'b0; d_wr = 1'b0; i_rd = 1'b0;
    step();
    check1("done_one_cycle", d_done || i_done, 1'b0);
    check1("busy_idle", busy, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check1("rst_rden", memory_rden, 1'b0);
    check1("rst_wren", memory_wren, 1'b0);
    check32("rst_addr", memory_addr, 32'h0);
    check32("rst_wval", memory_write_val, 32'h0);
    check32("rst_d_rdata", d_rdata, 32'h0);
    check32("rst_i_rdata", i_rdata, 32'h0);
    check1("rst_d_done", d_done, 1'b0);
    check1("rst_i_done", i_done, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_err", err, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    int k;

    // Reset state
    repeat (3) step();
    check_reset_outputs();
    rst = 1'b0;
    step();
    check_reset_outputs();

    // Single read, response 2 strobe cycles in
    mem[32'h10] = 32'hCAFEF00D;
    do_txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 2);
    check32("single_read_val", d_rdata, 32'hCAFEF00D);

    // Read+write together is a write; rdata unchanged
    do_txn(1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678, 1);
    check32("rw_keeps_rdata", d_rdata, 32'hCAFEF00D);
    do_txn(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1);
    check32("fetch_sees_write", i_rdata, 32'h12345678);

    // Stray response in IDLE
    memory_read_val = 32'h55555555;
    memory_response = 1'b1;
    step();
    check1("stray_d_done", d_done, 1'b0);
    check1("stray_i_done", i_done, 1'b0);
    check1("stray_busy", busy, 1'b0);
    memory_response = 1'b0;
    step();
    check32("stray_d_rdata", d_rdata, exp_d_rdata);
    check32("stray_i_rdata", i_rdata, exp_i_rdata);
    check1("stray_no_strobe", memory_rden || memory_wren, 1'b0);

    // Contention with both requests held: grants alternate
    d_rd = 1'b1; d_addr = 32'h100;
    i_rd = 1'b1; i_addr = 32'h200;
    for (int t = 0; t < 6; t++) begin
      bit p;
      int dly;
      p   = !last_fetch;
      dly = (t < 4) ? 1 : int'($urandom_range(3, 1));
      serve(p, 1'b0, p ? 32'h200 : 32'h100, 32'h0, dly, 1'b0, cyc);
      check32("contention_gap", 32'(cyc), 32'((t == 0 ? 1 : 2) + dly));
    end
    d_rd = 1'b0; i_rd = 1'b0;
    step();
    step();
    check1("contention_idle", busy, 1'b0);

    // Random single-port traffic over a small address set
    for (int t = 0; t < 16; t++) begin
      bit          p;
      int          mode;
      logic [31:0] a;
      p    = 1'($urandom_range(1, 0));
      mode = int'($urandom_range(2, 0));
      a    = 32'($urandom_range(7, 0)) << 2;
      do_txn(p, mode != 1, mode != 0, a, $urandom, int'($urandom_range(4, 1)));
    end

`ifdef MEM_TIMEOUT_EN
    // Fetch with no response: abort after 8 BUSY cycles
    i_rd = 1'b1; i_addr = 32'h40;
    k = 0;
    while (!memory_rden && k < 6) begin step(); k++; end
    k = 0;
    while (memory_rden && k < 20) begin k++; step(); end
    exp_err     = 1'b1;
    exp_i_rdata = 32'hDEADBEEF;
    last_fetch  = 1'b1;
    check32("timeout_cycles", 32'(k), 32'd8);
    check1("timeout_i_done", i_done, 1'b1);
    check32("timeout_poison", i_rdata, 32'hDEADBEEF);
    check1("timeout_err", err, 1'b1);
    i_rd = 1'b0;
    step();
    check1("err_sticky", err, 1'b1);
    do_txn(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 2);
    check1("err_sticky_after_txn", err, 1'b1);
`endif

    // Reset in the middle of a read
    d_rd = 1'b1; d_addr = 32'h80;
    k = 0;
    while (!memory_rden && k < 6) begin step(); k++; end
    check1("pre_reset_rden", memory_rden, 1'b1);
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    d_rd = 1'b0;
    step();
    rst = 1'b0;
    exp_d_rdata = '0;
    exp_i_rdata = '0;
    exp_err     = 1'b0;
    last_fetch  = 1'b1;
    k = 0;
    for (int t = 0; t < 4; t++) begin
      step();
      if (d_done || i_done || busy) k++;
    end
    check32("no_done_after_reset", 32'(k), 32'd0);

    // Tie right after reset goes to the data port
    d_rd = 1'b1; d_addr = 32'h8;
    i_rd = 1'b1; i_addr = 32'hC;
    serve(1'b0, 1'b0, 32'h8, 32'h0, 1, 1'b0, cyc);
    d_rd = 1'b0; i_rd = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Two-requester sequencer that shares the single external memory bus (memory_addr / memory_rden / memory_wren / memory_write_val / memory_read_val / memory_response) between the data port and the instruction-fetch port of the single-cycle core. It registers one transaction at a time, holds the strobe until the memory answers, returns read data, and raises a per-port done pulse. The core stalls on a busy port until its done pulse.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 64, max cycles in BUSY before abort (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- d_rd  in  1  data-port read request; held until d_done
- d_wr  in  1  data-port write request; held until d_done
- d_addr  in  AW  data-port address
- d_wdata  in  DW  data-port write data
- d_rdata  out  DW  data-port read result; valid when d_done is high
- d_done  out  1  one-cycle completion pulse, data port
- i_rd  in  1  fetch read request; held until i_done
- i_addr  in  AW  fetch address
- i_rdata  out  DW  fetch read result; valid when i_done is high
- i_done  out  1  one-cycle completion pulse, fetch port
- busy  out  1  high in BUSY and DONE
- memory_addr  out  32  registered bus address
- memory_rden  out  1  read strobe
- memory_wren  out  1  write strobe
- memory_write_val  out  32  registered write data
- memory_read_val  in  32  bus read data, valid with memory_response
- memory_response  in  1  transaction acknowledge
- err  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if any request is pending, arbitrate and latch address, write data, direction and grant id on the clock edge; go to BUSY. If no request is pending, stay in IDLE.
- Arbitration, both ports pending: round-robin. The port not granted last wins. After reset the data port wins first. A single pending port always wins.
- d_rd and d_wr both high: the request is treated as a write. memory_rden stays low.
- BUSY: exactly one of memory_rden / memory_wren is high, and memory_addr / memory_write_val are stable. On the edge where memory_response=1:
  - capture memory_read_val into the granted port's rdata register. Writes leave rdata unchanged.
  - drop the strobe and go to DONE.
- DONE: the granted port's done is high for exactly this cycle. All requests are ignored. Return to IDLE next cycle. The requester may drop or change its request during DONE.
- memory_response outside BUSY is ignored.
- Address and data changes on the inputs during BUSY have no effect.
- Arithmetic: the internal address is AW bits wide. It is zero-extended or truncated to 32 bits on memory_addr.

## Timing
- Reset values:
  - state IDLE
  - memory_rden=0, memory_wren=0
  - memory_addr=0, memory_write_val=0
  - d_rdata=0, i_rdata=0
  - d_done=0, i_done=0
  - busy=0, err=0
  - last-grant pointer = fetch, so the data port wins first
- Reset asserted mid-transaction: strobes drop asynchronously and no done is issued. The requester re-issues after reset.
- Latency from request seen in IDLE to done: 1 + N + 1 cycles, where N ≥ 1 is the number of BUSY cycles up to and including the response edge. Minimum is 3 cycles.
- Back-to-back transactions: a new grant is possible in the IDLE cycle right after DONE, so one IDLE cycle separates transactions.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- MEM_TIMEOUT_EN defined: a counter runs in BUSY and clears on entry.
  - If TIMEOUT cycles elapse without memory_response, drop the strobe and go to DONE.
  - The done pulse fires, with rdata = 32'hDEADBEEF on a read.
  - err is set and stays set until rst.
- MEM_TIMEOUT_EN undefined: BUSY waits indefinitely, no counter is built, and err is tied 0.

## Structure
- Shared package mem_ctrl_pkg contains:
  - state enum (IDLE, BUSY, DONE)
  - grant id constants GNT_DATA / GNT_FETCH
  - poison constant 32'hDEADBEEF
- Sub-module mem_rr_arbiter: 2-way round-robin.
  - Inputs: two requests, plus an update enable pulsed on grant.
  - Output: a one-hot grant.
  - Holds the last-grant pointer.

## Test plan
- Single read: d_rd=1, d_addr=0x10; memory answers 2 cycles after strobe with 0xCAFEF00D -> memory_rden high for 2 cycles, memory_addr=0x10, d_rdata=0xCAFEF00D with a 1-cycle d_done, total latency 4 cycles.
- Write with simultaneous rd/wr: d_rd=d_wr=1, d_wdata=0x12345678 -> only memory_wren is asserted, memory_write_val=0x12345678, d_done pulses, d_rdata is unchanged.
- Contention: d_rd and i_rd held continuously with 1-cycle responses -> grants alternate D,I,D,I, each done pulse lasts 1 cycle, and each port's rdata matches its own address.
- Reset mid-BUSY: assert rst while memory_rden=1 -> all outputs return to reset values immediately, and no done fires after rst is released.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT=8): i_rd with no response -> memory_rden drops after 8 BUSY cycles, i_done pulses with i_rdata=0xDEADBEEF, and err stays 1 until rst.
- Stray response: pulse memory_response in IDLE -> no done, no state change, rdata unchanged.
